// File: rtl/data_mem_port.sv
// -----------------------------------------------------------------------------
// data_mem_port
//   Word-addressed data memory responder for the load/store path. Accepts one
//   load or store while idle, waits LATENCY cycles, then completes with a
//   one-cycle resp_valid strobe. read_data feeds the MemtoReg writeback mux.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 4)
//   LATENCY  wait cycles between accept and response (0..15)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   MemRead     load request (sampled only while req_ready=1)
//   MemWrite    store request (sampled only while req_ready=1); wins over load
//   addr        byte address; [log2(DEPTH)+1:2] word index, [1:0] byte select
//   write_data  store data
//   byte_en     store lane enables, bit i -> write_data[8i+7:8i]
//   req_ready   1 while idle and able to accept a request
//   resp_valid  one-cycle completion pulse
//   read_data   load result, held until the next load completes
//   err         misaligned-access flag, valid with resp_valid
//
// Build option
//   DATA_MEM_MISALIGN_CHECK_EN  enables misalignment checking; when undefined,
//                               addr[1:0] is ignored and err is tied to 0.
// -----------------------------------------------------------------------------
module data_mem_port #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic [3:0]  byte_en,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] read_data,
   output logic        err
);

   localparam int unsigned IW  = $clog2(DEPTH);
   localparam logic [3:0]  LAT = 4'(LATENCY);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q,   cnt_d;
   logic [IW-1:0] idx_q,   idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    ben_q,   ben_d;
   logic          store_q, store_d;
   logic          mis_q,   mis_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          mis_now;

   logic [31:0]   mem_q [DEPTH];

   // Upper address bits are intentionally ignored (wrap modulo DEPTH).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:IW+2], addr[1:0]};

`ifdef DATA_MEM_MISALIGN_CHECK_EN
   assign mis_now = ((byte_en == 4'b1111) && (addr[1:0] != 2'b00)) ||
                    (((byte_en == 4'b0011) || (byte_en == 4'b1100)) && addr[0]);
`else
   assign mis_now = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      ben_d   = ben_q;
      store_d = store_q;
      mis_d   = mis_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (MemRead || MemWrite) begin
               idx_d   = addr[IW+1:2];
               wdata_d = write_data;
               ben_d   = byte_en;
               store_d = MemWrite;
               mis_d   = mis_now;
               cnt_d   = LAT;
               state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Load data is captured on the edge entering RESP so it is already
      // valid during the resp_valid cycle; the _d values cover LATENCY=0.
      if ((state_d == S_RESP) && (state_q != S_RESP) && !store_d && !mis_d) begin
         rdata_d = mem_q[idx_d];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         ben_q   <= '0;
         store_q <= 1'b0;
         mis_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         ben_q   <= ben_d;
         store_q <= store_d;
         mis_q   <= mis_d;
         rdata_q <= rdata_d;
      end
   end

   // Array is not reset; a store commits only on an un-reset RESP edge.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == S_RESP) && store_q && !mis_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (ben_q[i]) begin
               mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   // Gated by reset so an aborted request never shows a completion.
   assign resp_valid = (state_q == S_RESP) && !reset;
   assign read_data  = rdata_q;

`ifdef DATA_MEM_MISALIGN_CHECK_EN
   assign err = resp_valid && mis_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_port.sv
// -----------------------------------------------------------------------------
// tb_data_mem_port
//   Directed self-checking bench for data_mem_port (DEPTH=256, LATENCY=2).
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_data_mem_port;

   localparam int unsigned DEPTH   = 256;
   localparam int unsigned LATENCY = 2;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [3:0]  byte_en;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] read_data;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   data_mem_port #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .addr       (addr),
      .write_data (write_data),
      .byte_en    (byte_en),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .read_data  (read_data),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issues one request at the current falling edge and watches an 8-cycle
   // window. Optionally pulses MemRead (addr 0x20) or reset in the first
   // WAIT cycle. Reports the cycle index of the first resp_valid (0 = none),
   // the number of resp_valid cycles, and read_data/err at the first response.
   task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic mid_rd, input logic mid_rst,
                          output int first, output int cnt,
                          output logic [31:0] data, output logic e,
                          output logic rdy1);
      MemRead    = rd;
      MemWrite   = wr;
      addr       = a;
      write_data = wd;
      byte_en    = be;
      first = 0;
      cnt   = 0;
      data  = '0;
      e     = 1'b0;
      rdy1  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            cnt++;
            if (first == 0) begin
               first = i;
               data  = read_data;
               e     = err;
            end
         end
         if (i == 1) rdy1 = req_ready;
         MemRead  = (i == 1) && mid_rd;
         MemWrite = 1'b0;
         if ((i == 1) && mid_rd) addr = 32'h20;
         reset    = (i == 1) && mid_rst;
      end
   endtask

   int          first;
   int          cnt;
   logic [31:0] data;
   logic        e;
   logic        rdy1;

   initial begin
      reset      = 1'b1;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      addr       = '0;
      write_data = '0;
      byte_en    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", read_data, 32'h0);
      check("rst_err",   32'(err), 32'd0);
      reset = 1'b0;

      // Store/load round trip
      run_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("st_lat",  32'(first), 32'd3);
      check("st_cnt",  32'(cnt), 32'd1);
      check("st_err",  32'(e), 32'd0);
      check("st_rdy1", 32'(rdy1), 32'd0);
      run_req(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("ld_lat",  32'(first), 32'd3);
      check("ld_data", data, 32'hDEADBEEF);
      check("ld_hold", read_data, 32'hDEADBEEF);

      // Byte lanes
      run_req(1'b0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      run_req(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("lane_st_cnt", 32'(cnt), 32'd1);
      run_req(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("lane_data", data, 32'h11BB33DD);

      // Back-pressure: MemRead pulsed during WAIT is ignored
      run_req(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b1, 1'b0, first, cnt, data, e, rdy1);
      check("bp_cnt",  32'(cnt), 32'd1);
      check("bp_lat",  32'(first), 32'd3);
      check("bp_data", data, 32'hDEADBEEF);

      // Store priority: load dropped, read_data untouched
      run_req(1'b1, 1'b1, 32'h30, 32'h55667788, 4'b1111, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("prio_cnt",  32'(cnt), 32'd1);
      check("prio_data", data, 32'hDEADBEEF);
      run_req(1'b1, 1'b0, 32'h30, 32'h0, 4'b0000, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("prio_ld", data, 32'h55667788);

      // Store with no lanes enabled completes but changes nothing
      run_req(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("be0_cnt", 32'(cnt), 32'd1);
      run_req(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("be0_data", data, 32'h11BB33DD);

      // Reset during WAIT of a store, then wrapped load of word 0
      run_req(1'b0, 1'b1, 32'h0, 32'h01020304, 4'b1111, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      run_req(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b1, first, cnt, data, e, rdy1);
      check("abort_cnt",   32'(cnt), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      run_req(1'b1, 1'b0, 32'(4*DEPTH), 32'h0, 4'b0000, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("wrap_lat",  32'(first), 32'd3);
      check("wrap_data", data, 32'h01020304);

`ifdef DATA_MEM_MISALIGN_CHECK_EN
      run_req(1'b0, 1'b1, 32'h22, 32'h0BADCAFE, 4'b1111, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("mis_cnt", 32'(cnt), 32'd1);
      check("mis_err", 32'(e), 32'd1);
      run_req(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("mis_data",  data, 32'h11BB33DD);
      check("mis_err_ld", 32'(e), 32'd0);
`else
      run_req(1'b0, 1'b1, 32'h22, 32'h0BADCAFE, 4'b1111, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("low_cnt", 32'(cnt), 32'd1);
      check("low_err", 32'(e), 32'd0);
      run_req(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 1'b0, first, cnt, data, e, rdy1);
      check("low_data", data, 32'h0BADCAFE);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
